// File: rtl/frequency_measure_sequencer.sv
`timescale 1ns/1ps
// frequency_measure_sequencer
// Runs one measurement cycle of the per-pixel frequency analyzer bank:
// clear -> fixed-length enable window -> settle -> snapshot -> stream out.
//
// Ports
//   s00_axi_aclk / s00_axi_aresetn : clock, async active-low reset
//   cmd_start / cmd_dump / cmd_abort / irq_ack : one-cycle command pulses
//   f_values        : analyzer outputs, word k = 2*ch + {0:f1, 1:f2}
//   analyzer_clear / analyzer_enable : analyzer bank controls
//   m_tdata / m_tvalid / m_tready / m_tlast : AXI-Stream master (dump)
//   busy    : not IDLE
//   irq     : dump completed (level, cleared by irq_ack or next command)
//   aborted : sticky, last run ended by abort
module frequency_measure_sequencer #(
  parameter int CHANNELS      = 3,
  parameter int DATA_WIDTH    = 32,
  parameter int WINDOW_CYCLES = 100000000,
  parameter int CLEAR_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                               s00_axi_aclk,
  input  logic                               s00_axi_aresetn,
  input  logic                               cmd_start,
  input  logic                               cmd_dump,
  input  logic                               cmd_abort,
  input  logic                               irq_ack,
  input  logic [CHANNELS*2*DATA_WIDTH-1:0]   f_values,
  output logic                               analyzer_clear,
  output logic                               analyzer_enable,
  output logic [DATA_WIDTH-1:0]              m_tdata,
  output logic                               m_tvalid,
  input  logic                               m_tready,
  output logic                               m_tlast,
  output logic                               busy,
  output logic                               irq,
  output logic                               aborted
);

  localparam int WORDS = 2 * CHANNELS;
  localparam int MAX_A = (WINDOW_CYCLES > CLEAR_CYCLES) ? WINDOW_CYCLES : CLEAR_CYCLES;
  localparam int MAX_C = (MAX_A > SETTLE_CYCLES) ? MAX_A : SETTLE_CYCLES;
  localparam int CNT_W = $clog2(MAX_C + 1);
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  // Counter reload values: a phase of N cycles counts N-1 down to 0.
  localparam logic [CNT_W-1:0] CLEAR_LOAD  = CNT_W'(CLEAR_CYCLES - 1);
  localparam logic [CNT_W-1:0] WINDOW_LOAD = CNT_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = (SETTLE_CYCLES > 0) ? CNT_W'(SETTLE_CYCLES - 1) : '0;
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(WORDS - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CLEAR    = 3'd1;
  localparam logic [2:0] S_MEASURE  = 3'd2;
  localparam logic [2:0] S_SETTLE   = 3'd3;
  localparam logic [2:0] S_SNAPSHOT = 3'd4;
  localparam logic [2:0] S_DUMP     = 3'd5;

  logic [2:0]                        state_q, state_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic [IDX_W-1:0]                  idx_q, idx_d;
  logic [WORDS-1:0][DATA_WIDTH-1:0]  shadow_q, shadow_d;
  logic                              irq_q, irq_d;
  logic                              aborted_q, aborted_d;
  logic                              clear_q, clear_d;
  logic                              enable_q, enable_d;
  logic                              tvalid_q, tvalid_d;
  logic                              tlast_q, tlast_d;
  logic [DATA_WIDTH-1:0]             tdata_q, tdata_d;
  logic                              busy_q, busy_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    irq_d     = irq_q;
    aborted_d = aborted_q;

    // Ack is applied first so that a same-cycle completion below wins.
    if (irq_ack) irq_d = 1'b0;

    if (cmd_abort && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      aborted_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_start) begin
            state_d   = S_CLEAR;
            cnt_d     = CLEAR_LOAD;
            irq_d     = 1'b0;
            aborted_d = 1'b0;
          end else if (cmd_dump) begin
            state_d   = S_SNAPSHOT;
            irq_d     = 1'b0;
            aborted_d = 1'b0;
          end
        end
        S_CLEAR: begin
          if (cnt_q == '0) begin
            state_d = S_MEASURE;
            cnt_d   = WINDOW_LOAD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_MEASURE: begin
          if (cnt_q == '0) begin
            state_d = (SETTLE_CYCLES > 0) ? S_SETTLE : S_SNAPSHOT;
            cnt_d   = SETTLE_LOAD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_SETTLE: begin
          if (cnt_q == '0) state_d = S_SNAPSHOT;
          else             cnt_d   = cnt_q - 1'b1;
        end
        S_SNAPSHOT: begin
          shadow_d = f_values;
          idx_d    = '0;
          state_d  = S_DUMP;
        end
        S_DUMP: begin
          // m_tvalid is high for the whole DUMP state, so ready alone is the handshake.
          if (m_tready) begin
            if (idx_q == LAST_IDX) begin
              state_d = S_IDLE;
              irq_d   = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Outputs are decoded from next state so they come straight off flops.
    clear_d  = (state_d == S_CLEAR);
    enable_d = (state_d == S_MEASURE);
    tvalid_d = (state_d == S_DUMP);
    tlast_d  = tvalid_d && (idx_d == LAST_IDX);
    tdata_d  = tvalid_d ? shadow_d[idx_d] : '0;
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shadow_q  <= '0;
      irq_q     <= 1'b0;
      aborted_q <= 1'b0;
      clear_q   <= 1'b0;
      enable_q  <= 1'b0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      tdata_q   <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      irq_q     <= irq_d;
      aborted_q <= aborted_d;
      clear_q   <= clear_d;
      enable_q  <= enable_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      tdata_q   <= tdata_d;
      busy_q    <= busy_d;
    end
  end

  assign analyzer_clear  = clear_q;
  assign analyzer_enable = enable_q;
  assign m_tvalid        = tvalid_q;
  assign m_tlast         = tlast_q;
  assign m_tdata         = tdata_q;
  assign busy            = busy_q;
  assign irq             = irq_q;
  assign aborted         = aborted_q;

endmodule

// File: tb/tb_frequency_measure_sequencer.sv
`timescale 1ns/1ps
// Directed bench for frequency_measure_sequencer with a stream scoreboard.
module tb_frequency_measure_sequencer;

  localparam int CH = 3;
  localparam int DW = 32;
  localparam int NW = 2 * CH;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cmd_start = 1'b0, cmd_dump = 1'b0, cmd_abort = 1'b0, irq_ack = 1'b0;
  logic [NW*DW-1:0] f_values = '0;
  logic            analyzer_clear, analyzer_enable, m_tvalid, m_tlast, busy, irq, aborted;
  logic            m_tready = 1'b1;
  logic [DW-1:0]   m_tdata;

  int n_cmp = 0;
  int n_err = 0;
  int hs_cnt = 0;
  logic [DW:0] sb[$];

  frequency_measure_sequencer #(
    .CHANNELS(CH), .DATA_WIDTH(DW), .WINDOW_CYCLES(10), .CLEAR_CYCLES(2), .SETTLE_CYCLES(2)
  ) dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
    .cmd_start(cmd_start), .cmd_dump(cmd_dump), .cmd_abort(cmd_abort), .irq_ack(irq_ack),
    .f_values(f_values),
    .analyzer_clear(analyzer_clear), .analyzer_enable(analyzer_enable),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .busy(busy), .irq(irq), .aborted(aborted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_f(input logic [DW-1:0] base);
    for (int k = 0; k < NW; k++) f_values[k*DW +: DW] = base + DW'(k);
  endtask

  // Expected stream: {tlast, tdata} for words first..last of the current f_values.
  task automatic push_exp(input int first, input int last);
    for (int k = first; k <= last; k++) sb.push_back({(k == NW-1), f_values[k*DW +: DW]});
  endtask

  // Stream monitor: pops the scoreboard on each handshake, checks stall stability.
  logic          prev_stall = 1'b0;
  logic [DW:0]   prev_word;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && m_tvalid) check("stall_stable", {m_tlast, m_tdata}, prev_word);
      if (m_tvalid && m_tready) begin
        hs_cnt++;
        if (sb.size() == 0) check("unexpected_word", {m_tlast, m_tdata}, 64'hDEAD_0000_0000);
        else                check("stream_word", {m_tlast, m_tdata}, sb.pop_front());
      end
      prev_stall = m_tvalid && !m_tready;
      prev_word  = {m_tlast, m_tdata};
    end
  end

  // Steps until busy drops; optional 1,0,0 ready pattern and input corruption in DUMP.
  task automatic run_idle(input int budget, input bit bp, input bit corrupt,
                          output int clr, output int en);
    int cyc;
    bit prev_last;
    cyc = 0;
    clr = analyzer_clear;
    en  = analyzer_enable;
    while (busy && cyc < budget) begin
      if (bp) m_tready = (cyc % 3 == 0);
      prev_last = m_tvalid && m_tready && m_tlast;
      tick();
      cyc++;
      if (corrupt && m_tvalid) f_values = {NW{32'hFF}};
      clr += analyzer_clear;
      en  += analyzer_enable;
      if (prev_last) begin
        check("irq_after_last", irq, 1);
        check("busy_after_last", busy, 0);
      end
    end
    check("run_timeout", busy, 0);
    m_tready = 1'b1;
  endtask

  task automatic pulse_start();
    cmd_start = 1'b1; tick(); cmd_start = 1'b0;
  endtask

  task automatic pulse_dump();
    cmd_dump = 1'b1; tick(); cmd_dump = 1'b0;
  endtask

  initial begin
    int clr, en, hs0, c;

    // Reset state
    tick(); tick();
    check("reset_outs", {analyzer_clear, analyzer_enable, m_tvalid, m_tlast, m_tdata, busy, irq, aborted}, 0);
    rst_n = 1'b1;
    tick();

    // Reset in the middle of the measurement window
    set_f(32'h11);
    pulse_start();
    check("rst_run_clear", analyzer_clear, 1);
    tick();
    tick();
    check("rst_run_enable", analyzer_enable, 1);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check("async_reset_outs", {analyzer_clear, analyzer_enable, m_tvalid, m_tlast, m_tdata, busy, irq, aborted}, 0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    check("post_reset_idle", {busy, analyzer_enable, irq}, 0);

    // Full run, ready held high
    set_f(32'h11);
    hs0 = hs_cnt;
    pulse_start();
    push_exp(0, NW-1);
    check("start_clear", analyzer_clear, 1);
    check("start_busy", busy, 1);
    run_idle(200, 0, 0, clr, en);
    check("clear_cycles", clr, 2);
    check("enable_cycles", en, 10);
    check("full_handshakes", hs_cnt - hs0, NW);
    check("irq_set", irq, 1);

    // Backpressure with inputs changing during DUMP
    set_f(32'h11);
    hs0 = hs_cnt;
    pulse_start();
    push_exp(0, NW-1);
    check("start_clears_irq", irq, 0);
    run_idle(300, 1, 1, clr, en);
    check("bp_handshakes", hs_cnt - hs0, NW);
    check("bp_sb_empty", sb.size(), 0);

    // Dump from IDLE; start during DUMP ignored
    set_f(32'h21);
    hs0 = hs_cnt;
    pulse_dump();
    push_exp(0, NW-1);
    check("dump_snapshot_valid", m_tvalid, 0);
    check("dump_busy", busy, 1);
    tick();
    check("dump_first_valid", m_tvalid, 1);
    check("dump_first_data", m_tdata, 32'h21);
    pulse_start();
    run_idle(100, 0, 0, clr, en);
    check("dump_no_enable", en, 0);
    check("dump_no_clear", clr, 0);
    check("dump_handshakes", hs_cnt - hs0, NW);
    tick();
    check("start_in_dump_ignored", busy, 0);

    // Abort together with start after three words
    set_f(32'h31);
    m_tready = 1'b0;
    pulse_start();
    push_exp(0, 2);
    c = 0;
    while (!m_tvalid && c < 100) begin tick(); c++; end
    check("abort_wait_valid", m_tvalid, 1);
    m_tready = 1'b1;
    repeat (3) tick();
    check("abort_at_word3", m_tdata, 32'h34);
    m_tready = 1'b0; cmd_abort = 1'b1; cmd_start = 1'b1;
    tick();
    cmd_abort = 1'b0; cmd_start = 1'b0;
    check("abort_outs", {m_tvalid, m_tlast, analyzer_clear, analyzer_enable, busy}, 0);
    check("abort_flag", aborted, 1);
    check("abort_irq", irq, 0);
    m_tready = 1'b1;
    tick();
    check("abort_stays_idle", busy, 0);
    pulse_start();
    push_exp(0, NW-1);
    check("start_clears_aborted", aborted, 0);
    run_idle(200, 0, 0, clr, en);
    check("post_abort_enable", en, 10);

    // Abort in IDLE has no effect
    cmd_abort = 1'b1; tick(); cmd_abort = 1'b0;
    check("idle_abort_noop", {aborted, busy}, 0);

    // irq set beats irq_ack in the same cycle
    set_f(32'h41);
    m_tready = 1'b0;
    pulse_dump();
    push_exp(0, NW-1);
    c = 0;
    while (!m_tvalid && c < 20) begin tick(); c++; end
    m_tready = 1'b1;
    repeat (NW-1) tick();
    check("irq_last_visible", {m_tvalid, m_tlast}, 2'b11);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check("irq_set_beats_ack", irq, 1);
    tick();
    check("irq_holds", irq, 1);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check("irq_ack_clears", irq, 0);

    tick(); tick();
    check("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
